pipe_hold_ctrl: RTL and testbench
=================================

Name: pipe_hold_ctrl

Overview:
- Control end of the pipeline-register hold interface: the only producer of hold_flag for pc_reg, if_id, id_ex and the other stage registers.
- Merges stall and flush requests from ex, the bus arbiter, the load-use detector in id, and the interrupt controller.
- Forwards the winning redirect (jump or interrupt) to pc_reg.
- A small FSM stretches a flush or stall over a configurable number of cycles, so fetch latency above one cycle cannot leak wrong-path instructions.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- FLUSH_CYCLES, 2, total cycles Hold_Id is asserted per redirect, counting the redirect cycle; legal range 1..15.
- LU_CYCLES, 1, total cycles Hold_If is asserted per load-use hazard; legal range 1..15.
- CNT_W, 32, width of the stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- jump_flag_i  in  1  ex requests a redirect
- jump_addr_i  in  32  ex redirect target
- hold_flag_ex_i  in  1  ex multi-cycle operation busy (div)
- hold_flag_rib_i  in  1  bus arbiter has granted a non-core master
- load_use_i  in  1  id detected a load-use hazard
- int_assert_i  in  1  interrupt controller redirect
- int_addr_i  in  32  interrupt/trap target
- clr_cnt_i  in  1  clear stall counter
- hold_flag_o  out  3  Hold_Flag_Bus: Hold_None=0, Hold_Pc=1, Hold_If=2, Hold_Id=3
- jump_flag_o  out  1  redirect to pc_reg
- jump_addr_o  out  32  redirect target
- busy_o  out  1  FSM not in IDLE
- stall_cnt_o  out  CNT_W  cycles with hold_flag_o != Hold_None

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - While rst=1: hold_flag_o=Hold_Id, jump_flag_o=0, jump_addr_o=0, busy_o=0.
  - At the first clk edge with rst=1: state becomes IDLE, cnt becomes 0, stall_cnt_o becomes 0.
  - Reset mid-flush or mid-stall aborts it with no residual hold.
- Redirect (combinational, zero latency):
  - redir = int_assert_i | jump_flag_i.
  - int_assert_i has priority: jump_addr_o=int_addr_i.
  - Otherwise jump_addr_o=jump_addr_i when jump_flag_i=1, else 0.
  - jump_flag_o=redir.
- Request level (combinational): req_lvl = max of the following.
  - Hold_Id if redir or hold_flag_ex_i.
  - Hold_If if load_use_i.
  - Hold_Pc if hold_flag_rib_i.
  - Otherwise Hold_None.
- Output level: hold_flag_o = max(req_lvl, fsm_lvl). fsm_lvl is Hold_None in IDLE, Hold_Id in FLUSH, Hold_If in LUSTALL.
- FSM, with 4-bit down-counter cnt; all transitions are at the clk edge.
  - IDLE:
    - If redir and FLUSH_CYCLES>1: go to FLUSH, cnt=FLUSH_CYCLES-2.
    - Else if load_use_i and LU_CYCLES>1: go to LUSTALL, cnt=LU_CYCLES-2.
    - Else stay in IDLE.
  - FLUSH:
    - If redir: stay, reload cnt=FLUSH_CYCLES-2 (a back-to-back interrupt restarts the window).
    - Else if cnt==0: go to IDLE.
    - Else cnt-=1.
  - LUSTALL:
    - If redir: apply the same rule as redir in IDLE (redirect preempts the stall).
    - Else if load_use_i: reload cnt=LU_CYCLES-2.
    - Else if cnt==0: go to IDLE.
    - Else cnt-=1.
  - When a parameter is 1, the corresponding event lasts a single combinational cycle and never leaves IDLE.
- Simultaneous events:
  - A redirect overrides load-use, both for the level and for the next state.
  - hold_flag_ex_i and hold_flag_rib_i never change FSM state; they only raise the level while asserted.
- Stall counter, updated at the clk edge:
  - rst or clr_cnt_i: set to 0 (clear wins over increment).
  - Else if hold_flag_o!=Hold_None and stall_cnt_o != all-ones: increment.
  - Saturates at all-ones, with no wrap.
- busy_o = (state!=IDLE). It is registered-state derived and glitch-free.

Decomposition:
- Shared defines (existing defines.v):
  - Hold_Flag_Bus and the Hold_None/Hold_Pc/Hold_If/Hold_Id encodings.
  - JumpEnable/JumpDisable.
  - ZeroWord.
- New shared constants: FSM state encodings PHC_IDLE=2'd0, PHC_FLUSH=2'd1, PHC_LUSTALL=2'd2.
- One sub-module: sat_counter (parameterised width, synchronous clear, enable, saturate). It is reusable for other performance counters.
- The level max is a local function; no separate module.

Test Plan:
- rst=1 for 3 cycles with jump_flag_i=1, jump_addr_i=0x100 -> hold_flag_o=3, jump_flag_o=0, jump_addr_o=0, stall_cnt_o=0 after release.
- FLUSH_CYCLES=3; 1-cycle jump_flag_i with jump_addr_i=0x0000_0200 -> jump_flag_o=1 and jump_addr_o=0x200 the same cycle; hold_flag_o=3 for exactly 3 cycles; busy_o=1 for 2 cycles; stall_cnt_o=3.
- Same cycle int_assert_i=1 (int_addr_i=0x8), jump_flag_i=1 (0x200), load_use_i=1 -> jump_addr_o=0x8, hold_flag_o=3, next state FLUSH (not LUSTALL).
- LU_CYCLES=2; load_use_i pulse -> hold_flag_o=2 for 2 cycles. A jump pulse during the second cycle -> hold_flag_o=3, then FLUSH_CYCLES-1 further Hold_Id cycles.
- hold_flag_rib_i=1 for 5 cycles overlapping hold_flag_ex_i=1 on cycles 3-4 -> hold_flag_o=1,1,3,3,1; busy_o stays 0.
- CNT_W=4; hold_flag_ex_i held 20 cycles -> stall_cnt_o saturates at 15. clr_cnt_i asserted together with the hold -> 0 on the next cycle.

Source files
------------

// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared constants for the pipeline hold controller: hold-bus encodings,
// redirect enables, the zero word and the hold FSM state encodings.
package pipe_hold_ctrl_pkg;

  // Hold_Flag_Bus encodings, ordered so a larger value is a stronger hold.
  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_IF   = 3'd2;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  localparam logic        JUMP_ENABLE  = 1'b1;
  localparam logic        JUMP_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  // Hold FSM states.
  typedef enum logic [1:0] {
    PHC_IDLE    = 2'd0,
    PHC_FLUSH   = 2'd1,
    PHC_LUSTALL = 2'd2
  } phc_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset/clear and count enable.
// Clear has priority over increment; the count sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ALL_ONE = {W{1'b1}};

  // Count enabled cycles, clearing on reset/clear and holding at saturation.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= {W{1'b0}};
    end else if (en && (cnt != ALL_ONE)) begin
      cnt <= cnt + ONE;
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold controller: merges stall/flush requests into the single
// Hold_Flag_Bus, forwards the winning redirect to pc_reg, stretches flushes
// and load-use stalls over several cycles, and counts stalled cycles.
module pipe_hold_ctrl
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned LU_CYCLES    = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_flag_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             hold_flag_ex_i,
  input  logic             hold_flag_rib_i,
  input  logic             load_use_i,
  input  logic             int_assert_i,
  input  logic [31:0]      int_addr_i,
  input  logic             clr_cnt_i,
  output logic [2:0]       hold_flag_o,
  output logic             jump_flag_o,
  output logic [31:0]      jump_addr_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // A window of one cycle is covered by the combinational request alone,
  // so the FSM only engages for windows longer than one cycle. The counter
  // reload is the window length minus the entry cycle and the final cycle.
  localparam logic       FLUSH_MULTI  = (FLUSH_CYCLES > 32'd1);
  localparam logic       LU_MULTI     = (LU_CYCLES > 32'd1);
  localparam logic [3:0] FLUSH_RELOAD = FLUSH_MULTI ? 4'(FLUSH_CYCLES - 32'd2) : 4'd0;
  localparam logic [3:0] LU_RELOAD    = LU_MULTI ? 4'(LU_CYCLES - 32'd2) : 4'd0;

  function automatic logic [2:0] lvl_max(input logic [2:0] a, input logic [2:0] b);
    return (a > b) ? a : b;
  endfunction

  phc_state_e  state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        redir_s;
  logic [31:0] redir_addr_s;
  logic [2:0]  req_lvl_s;
  logic [2:0]  fsm_lvl_s;
  logic        stall_en_s;

  assign redir_s = int_assert_i | jump_flag_i;

  // Select the redirect target; the interrupt controller wins over ex.
  always_comb begin
    redir_addr_s = ZERO_WORD;
    if (int_assert_i) begin
      redir_addr_s = int_addr_i;
    end else if (jump_flag_i) begin
      redir_addr_s = jump_addr_i;
    end else begin
      redir_addr_s = ZERO_WORD;
    end
  end

  // Strongest hold currently requested by any source.
  always_comb begin
    req_lvl_s = HOLD_NONE;
    if (hold_flag_rib_i) begin
      req_lvl_s = lvl_max(req_lvl_s, HOLD_PC);
    end else begin
      req_lvl_s = req_lvl_s;
    end
    if (load_use_i) begin
      req_lvl_s = lvl_max(req_lvl_s, HOLD_IF);
    end else begin
      req_lvl_s = req_lvl_s;
    end
    if (redir_s || hold_flag_ex_i) begin
      req_lvl_s = HOLD_ID;
    end else begin
      req_lvl_s = req_lvl_s;
    end
  end

  // Hold level implied by the stretching FSM.
  always_comb begin
    fsm_lvl_s = HOLD_NONE;
    case (state_r)
      PHC_FLUSH:   fsm_lvl_s = HOLD_ID;
      PHC_LUSTALL: fsm_lvl_s = HOLD_IF;
      default:     fsm_lvl_s = HOLD_NONE;
    endcase
  end

  // Next-state logic: redirects open/restart a flush window and preempt
  // load-use stalls; ex and bus holds never affect the state.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      PHC_IDLE: begin
        if (redir_s && FLUSH_MULTI) begin
          state_s = PHC_FLUSH;
          cnt_s   = FLUSH_RELOAD;
        end else if (load_use_i && LU_MULTI) begin
          state_s = PHC_LUSTALL;
          cnt_s   = LU_RELOAD;
        end else begin
          state_s = PHC_IDLE;
          cnt_s   = cnt_r;
        end
      end
      PHC_FLUSH: begin
        if (redir_s) begin
          state_s = PHC_FLUSH;
          cnt_s   = FLUSH_RELOAD;
        end else if (cnt_r == 4'd0) begin
          state_s = PHC_IDLE;
          cnt_s   = 4'd0;
        end else begin
          state_s = PHC_FLUSH;
          cnt_s   = cnt_r - 4'd1;
        end
      end
      PHC_LUSTALL: begin
        if (redir_s) begin
          if (FLUSH_MULTI) begin
            state_s = PHC_FLUSH;
            cnt_s   = FLUSH_RELOAD;
          end else begin
            state_s = PHC_IDLE;
            cnt_s   = 4'd0;
          end
        end else if (load_use_i) begin
          state_s = PHC_LUSTALL;
          cnt_s   = LU_RELOAD;
        end else if (cnt_r == 4'd0) begin
          state_s = PHC_IDLE;
          cnt_s   = 4'd0;
        end else begin
          state_s = PHC_LUSTALL;
          cnt_s   = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = PHC_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State and window counter registers; reset aborts any window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= PHC_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Drive the hold bus and redirect; reset forces a full hold, no redirect.
  always_comb begin
    hold_flag_o = HOLD_ID;
    jump_flag_o = JUMP_DISABLE;
    jump_addr_o = ZERO_WORD;
    busy_o      = 1'b0;
    if (rst) begin
      hold_flag_o = HOLD_ID;
      jump_flag_o = JUMP_DISABLE;
      jump_addr_o = ZERO_WORD;
      busy_o      = 1'b0;
    end else begin
      hold_flag_o = lvl_max(req_lvl_s, fsm_lvl_s);
      jump_flag_o = redir_s ? JUMP_ENABLE : JUMP_DISABLE;
      jump_addr_o = redir_addr_s;
      busy_o      = (state_r != PHC_IDLE);
    end
  end

  assign stall_en_s = (hold_flag_o != HOLD_NONE);

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt_i),
    .en  (stall_en_s),
    .cnt (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed-vector bench for pipe_hold_ctrl. The main instance uses
// FLUSH_CYCLES=3, LU_CYCLES=2, CNT_W=4; a second instance with single-cycle
// windows shares the inputs. Inputs change on the falling edge and outputs
// are checked 1ns later.
module tb_pipe_hold_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_ex_i;
  logic        hold_flag_rib_i;
  logic        load_use_i;
  logic        int_assert_i;
  logic [31:0] int_addr_i;
  logic        clr_cnt_i;
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        busy_o;
  logic [3:0]  stall_cnt_o;
  logic [2:0]  hold1;
  logic        jf1;
  logic [31:0] ja1;
  logic        busy1;
  logic [3:0]  cnt1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hold_ctrl #(.FLUSH_CYCLES(3), .LU_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_flag_ex_i(hold_flag_ex_i), .hold_flag_rib_i(hold_flag_rib_i),
    .load_use_i(load_use_i), .int_assert_i(int_assert_i), .int_addr_i(int_addr_i),
    .clr_cnt_i(clr_cnt_i), .hold_flag_o(hold_flag_o), .jump_flag_o(jump_flag_o),
    .jump_addr_o(jump_addr_o), .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
  );

  pipe_hold_ctrl #(.FLUSH_CYCLES(1), .LU_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_flag_ex_i(hold_flag_ex_i), .hold_flag_rib_i(hold_flag_rib_i),
    .load_use_i(load_use_i), .int_assert_i(int_assert_i), .int_addr_i(int_addr_i),
    .clr_cnt_i(clr_cnt_i), .hold_flag_o(hold1), .jump_flag_o(jf1),
    .jump_addr_o(ja1), .busy_o(busy1), .stall_cnt_o(cnt1)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    jump_flag_i     = 1'b0;
    jump_addr_i     = 32'h0;
    hold_flag_ex_i  = 1'b0;
    hold_flag_rib_i = 1'b0;
    load_use_i      = 1'b0;
    int_assert_i    = 1'b0;
    int_addr_i      = 32'h0;
    clr_cnt_i       = 1'b0;
  endtask

  // Advance one clock and settle just after the falling edge.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Check hold level and busy for the current cycle.
  task automatic chk_hb(input string tag, input logic [2:0] h, input logic b);
    #1;
    check_val({tag, "_hold"}, {29'd0, hold_flag_o}, {29'd0, h});
    check_val({tag, "_busy"}, {31'd0, busy_o}, {31'd0, b});
  endtask

  // Idle cycle with counter clear, so the next count starts from zero.
  task automatic clear_cnt();
    idle_inputs();
    clr_cnt_i = 1'b1;
    next_cycle();
    clr_cnt_i = 1'b0;
  endtask

  logic [2:0] rib_exp [5];

  initial begin
    rib_exp[0] = 3'd1; rib_exp[1] = 3'd1; rib_exp[2] = 3'd3;
    rib_exp[3] = 3'd3; rib_exp[4] = 3'd1;

    // Reset held three cycles while ex requests a jump.
    idle_inputs();
    rst         = 1'b1;
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h100;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("rst_hold", {29'd0, hold_flag_o}, 32'd3);
      check_val("rst_jf", {31'd0, jump_flag_o}, 32'd0);
      check_val("rst_ja", jump_addr_o, 32'd0);
      check_val("rst_busy", {31'd0, busy_o}, 32'd0);
      next_cycle();
    end
    rst = 1'b0;
    idle_inputs();
    #1;
    check_val("rel_cnt", {28'd0, stall_cnt_o}, 32'd0);
    check_val("rel_hold", {29'd0, hold_flag_o}, 32'd0);
    check_val("rel_busy", {31'd0, busy_o}, 32'd0);
    next_cycle();

    // One-cycle jump: three Hold_Id cycles, busy for two, count of three.
    clear_cnt();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0200;
    chk_hb("fl0", 3'd3, 1'b0);
    check_val("fl0_jf", {31'd0, jump_flag_o}, 32'd1);
    check_val("fl0_ja", jump_addr_o, 32'h200);
    check_val("p1_hold", {29'd0, hold1}, 32'd3);
    check_val("p1_ja", ja1, 32'h200);
    next_cycle();
    idle_inputs();
    chk_hb("fl1", 3'd3, 1'b1);
    check_val("fl1_jf", {31'd0, jump_flag_o}, 32'd0);
    check_val("p1_idle_hold", {29'd0, hold1}, 32'd0);
    check_val("p1_idle_busy", {31'd0, busy1}, 32'd0);
    next_cycle();
    chk_hb("fl2", 3'd3, 1'b1);
    next_cycle();
    chk_hb("fl3", 3'd0, 1'b0);
    check_val("fl_cnt", {28'd0, stall_cnt_o}, 32'd3);
    next_cycle();

    // Interrupt, jump and load-use together: interrupt target, flush wins.
    int_assert_i = 1'b1;
    int_addr_i   = 32'h8;
    jump_flag_i  = 1'b1;
    jump_addr_i  = 32'h200;
    load_use_i   = 1'b1;
    chk_hb("sim0", 3'd3, 1'b0);
    check_val("sim0_ja", jump_addr_o, 32'h8);
    check_val("sim0_jf", {31'd0, jump_flag_o}, 32'd1);
    next_cycle();
    idle_inputs();
    chk_hb("sim1", 3'd3, 1'b1);
    next_cycle();
    chk_hb("sim2", 3'd3, 1'b1);
    next_cycle();
    chk_hb("sim3", 3'd0, 1'b0);
    next_cycle();

    // Load-use pulse alone: two Hold_If cycles.
    load_use_i = 1'b1;
    chk_hb("lu0", 3'd2, 1'b0);
    next_cycle();
    idle_inputs();
    chk_hb("lu1", 3'd2, 1'b1);
    next_cycle();
    chk_hb("lu2", 3'd0, 1'b0);
    next_cycle();

    // Load-use pulse, jump in its second cycle preempts into a flush.
    load_use_i = 1'b1;
    chk_hb("lj0", 3'd2, 1'b0);
    next_cycle();
    idle_inputs();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h300;
    chk_hb("lj1", 3'd3, 1'b1);
    check_val("lj1_ja", jump_addr_o, 32'h300);
    next_cycle();
    idle_inputs();
    chk_hb("lj2", 3'd3, 1'b1);
    next_cycle();
    chk_hb("lj3", 3'd3, 1'b1);
    next_cycle();
    chk_hb("lj4", 3'd0, 1'b0);
    next_cycle();

    // Bus hold for five cycles with an ex hold on cycles 3-4.
    for (int i = 0; i < 5; i++) begin
      hold_flag_rib_i = 1'b1;
      hold_flag_ex_i  = (i == 2 || i == 3);
      chk_hb("rib", rib_exp[i], 1'b0);
      next_cycle();
    end
    idle_inputs();
    chk_hb("rib_end", 3'd0, 1'b0);
    next_cycle();

    // Reset in the middle of a flush leaves no residual hold.
    jump_flag_i = 1'b1;
    next_cycle();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    chk_hb("rst_mid", 3'd0, 1'b0);
    next_cycle();

    // ex hold for twenty cycles: counter saturates at 15.
    clear_cnt();
    hold_flag_ex_i = 1'b1;
    repeat (15) next_cycle();
    #1;
    check_val("sat15", {28'd0, stall_cnt_o}, 32'd15);
    repeat (5) next_cycle();
    #1;
    check_val("sat20", {28'd0, stall_cnt_o}, 32'd15);
    clr_cnt_i = 1'b1;
    next_cycle();
    clr_cnt_i = 1'b0;
    #1;
    check_val("clr_win", {28'd0, stall_cnt_o}, 32'd0);
    next_cycle();
    #1;
    check_val("after_clr", {28'd0, stall_cnt_o}, 32'd1);
    idle_inputs();
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
